// File: rtl/key_debounce_encoder.sv
// Twelve-key piano front end: per-key synchronise and debounce, then highest-note
// priority with a clamped octave and a one-cycle strobe on every note event.
module key_debounce_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] keys_in,
  input  logic [3:0]  octave_in,
  output logic [11:0] keys_db,
  output logic        note_valid,
  output logic [3:0]  note_idx,
  output logic [3:0]  note_octave,
  output logic        note_strobe
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  logic [11:0]   r_keys_s1;
  logic [11:0]   r_keys_s2;
  logic [3:0]    r_oct_s1;
  logic [3:0]    r_oct_s2;
  logic [11:0]   r_keys_db;
  logic [CW-1:0] r_cnt [12];

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_note_valid;
  logic [3:0]    r_note_idx;
  logic [3:0]    r_note_octave;
  logic          r_note_strobe;

  logic          w_any;
  logic [3:0]    w_sel_idx;
  logic [3:0]    w_oct_clamp;
  logic          w_valid_nxt;
  logic [3:0]    w_idx_nxt;
  logic [3:0]    w_oct_nxt;
  logic          w_strobe_nxt;

  // Two-flop synchronizers for the raw keys and octave select
  always_ff @(posedge clk) begin
    if (rst) begin
      r_keys_s1 <= 12'd0;
      r_keys_s2 <= 12'd0;
      r_oct_s1  <= 4'd0;
      r_oct_s2  <= 4'd0;
    end else begin
      r_keys_s1 <= keys_in;
      r_keys_s2 <= r_keys_s1;
      r_oct_s1  <= octave_in;
      r_oct_s2  <= r_oct_s1;
    end
  end

  // Per-key debounce: a disagreement must persist DEBOUNCE_CYCLES edges to flip the key
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) begin
        r_cnt[i] <= '0;
      end
      r_keys_db <= 12'd0;
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (r_keys_s2[i] == r_keys_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_cnt[i]     <= '0;
          r_keys_db[i] <= ~r_keys_db[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_any       = |r_keys_db;
  assign w_oct_clamp = (r_oct_s2 > 4'd8) ? 4'd8 : r_oct_s2;

  // Highest set debounced key wins
  always_comb begin
    w_sel_idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      w_sel_idx = r_keys_db[i] ? 4'(i) : w_sel_idx;
    end
  end

  // Note FSM next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_note_valid;
    w_idx_nxt    = r_note_idx;
    w_oct_nxt    = r_note_octave;
    w_strobe_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt  = HELD;
          w_valid_nxt  = 1'b1;
          w_idx_nxt    = w_sel_idx;
          w_oct_nxt    = w_oct_clamp;
          w_strobe_nxt = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      HELD: begin
        if (!w_any) begin
          w_state_nxt  = IDLE;
          w_valid_nxt  = 1'b0;
          w_strobe_nxt = 1'b1;
        end else if ((w_sel_idx != r_note_idx) || (w_oct_clamp != r_note_octave)) begin
          w_idx_nxt    = w_sel_idx;
          w_oct_nxt    = w_oct_clamp;
          w_strobe_nxt = 1'b1;
        end else begin
          w_state_nxt = HELD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // Note FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_note_valid  <= 1'b0;
      r_note_idx    <= 4'd0;
      r_note_octave <= 4'd0;
      r_note_strobe <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_note_valid  <= w_valid_nxt;
      r_note_idx    <= w_idx_nxt;
      r_note_octave <= w_oct_nxt;
      r_note_strobe <= w_strobe_nxt;
    end
  end

  assign keys_db     = r_keys_db;
  assign note_valid  = r_note_valid;
  assign note_idx    = r_note_idx;
  assign note_octave = r_note_octave;
  assign note_strobe = r_note_strobe;

endmodule

// File: doc/key_debounce_encoder.md
KEY_DEBOUNCE_ENCODER -- requirements
Module: key_debounce_encoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000 (1 ms at 1 MHz clk), legal range 2..65535; it sets the stable-input cycles required to change a debounced key.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port keys_in, input, 12 bits: raw asynchronous piano keys, active-high; bit i = semitone i (0=C .. 11=B).
REQ-005 The block SHALL have port octave_in, input, 4 bits: raw asynchronous octave select.
REQ-006 The block SHALL have port keys_db, output, 12 bits: debounced key states.
REQ-007 The block SHALL have port note_valid, output, 1 bit: 1 while at least one debounced key is pressed.
REQ-008 The block SHALL have port note_idx, output, 4 bits: selected semitone, range 0..11.
REQ-009 The block SHALL have port note_octave, output, 4 bits: clamped octave, range 0..8.
REQ-010 The block SHALL have port note_strobe, output, 1 bit: one-cycle pulse on every note-on, note-change or note-off event.

Function
REQ-011 keys_in and octave_in SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Each key SHALL have its own counter, ceil(log2(DEBOUNCE_CYCLES+1)) bits wide.
REQ-013 The counter SHALL clear whenever the synchronized key equals the corresponding keys_db bit.
REQ-014 The counter SHALL otherwise increment; keys_db toggles and the counter clears on the edge where the count would reach DEBOUNCE_CYCLES.
REQ-015 A raw key change held stable SHALL appear on keys_db exactly DEBOUNCE_CYCLES+2 edges after the first sampling edge.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change keys_db.
REQ-017 Priority SHALL be highest-note: the selected index is the highest set bit of keys_db.
REQ-018 Octave clamp: the synchronized octave SHALL map to min(octave, 8); values 9..15 yield 8.
REQ-019 The FSM SHALL have two states, IDLE and HELD.
REQ-020 IDLE->HELD when keys_db != 0: note_valid=1, note_idx=selected index, note_octave=clamped octave, note_strobe=1.
REQ-021 HELD->HELD when the selected index or clamped octave differs from the registered outputs: outputs update and note_strobe=1.
REQ-022 HELD->HELD with no such difference: no strobe, outputs hold.
REQ-023 HELD->IDLE when keys_db == 0: note_valid=0, note_strobe=1 (note-off); note_idx and note_octave hold their last values.
REQ-024 In IDLE, octave changes SHALL NOT update note_octave and SHALL NOT strobe.
REQ-025 note_* outputs SHALL be registered and SHALL update exactly 1 edge after the keys_db change that causes them.
REQ-026 A lower key pressed while a higher key is held SHALL produce no strobe; releasing the higher key SHALL then strobe with the lower index.
REQ-027 Simultaneous debounce of several keys on one edge SHALL produce a single strobe, carrying the highest index.
REQ-028 note_strobe SHALL never be high on two consecutive cycles unless the outputs changed on both cycles.

Reset
REQ-029 While rst=1 at an edge, synchronizers, counters, keys_db, note_valid, note_idx, note_octave and note_strobe SHALL all become 0, and the FSM SHALL enter IDLE.
REQ-030 Reset asserted mid-debounce or in HELD SHALL abort the operation with no strobe.
REQ-031 Keys held through reset SHALL be re-debounced after release, with full latency per REQ-015 and REQ-025.
REQ-032 Outputs SHALL be defined (non-X) from the first edge with rst=1.

Verification (DEBOUNCE_CYCLES=16)
REQ-033 Scenario: reset, then keys_in=0x800 and octave_in=4 held -> keys_db[11]=1 at edge 18; note_valid=1, note_idx=11, note_octave=4 and one-cycle note_strobe at edge 19.
REQ-034 Scenario: key bit 3 pulsed for 10 cycles -> keys_db, note_valid and note_strobe stay 0 throughout.
REQ-035 Scenario: keys_in=0x0FF held, then bits released one per 40 cycles from the top -> note_idx sequence 7,6,..,0, one strobe each; final release gives note_valid=0 with a strobe and note_idx=0 held.
REQ-036 Scenario: key 5 held, octave_in 4->12 -> note_octave=8 with one strobe, 3 edges after the change; octave changes in IDLE -> no strobe.
REQ-037 Scenario: keys 2 and 9 rise on the same cycle -> single strobe, note_idx=9; key 9 released -> strobe, note_idx=2.
REQ-038 Scenario: rst pulsed while in HELD with key held -> all outputs 0 without a strobe; note-on recurs DEBOUNCE_CYCLES+3 edges after rst falls.
